fetch_stage: RTL and testbench

Instruction-fetch stage for the 5-stage RISC-V pipeline. It owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, buffers returned words in a small in-order queue, and drives the IF/ID pipeline register consumed by decode. Branch/jump redirects from EX flush the queue and discard in-flight responses. Stalls from the hazard unit hold IF/ID.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests under a credit limit,
// queues returned words in order and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH  = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [31:0] q_pc    [FQ_DEPTH];
    logic [31:0] q_instr [FQ_DEPTH];
    logic [31:0] tag_mem [FQ_DEPTH];

    logic        ifid_valid_d;
    logic [31:0] ifid_pc_d, ifid_pc4_d, ifid_instr_d;

    logic             grant, rvalid_v, resp_ok, deq;
    logic [SUM_W-1:0] credit_sum;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign imem_addr      = pc_q;

    // Handshake qualifiers; responses with nothing in flight (e.g. after reset) are ignored
    always_comb begin
        rvalid_v   = imem_rvalid && (inflight_q != '0);
        resp_ok    = rvalid_v && (drop_q == '0) && !redirect_valid;
        deq        = !redirect_valid && !stall && (occ_q != '0);
        credit_sum = SUM_W'(inflight_q) + SUM_W'(occ_q) - SUM_W'(deq);
        imem_req   = !rst && !redirect_valid && (credit_sum < SUM_W'(FQ_DEPTH));
        grant      = imem_req && imem_gnt;
    end

    // PC, credit counters, queue and tag FIFO pointers
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(rvalid_v);
        drop_d     = drop_q;
        occ_d      = occ_q + CNT_W'(resp_ok) - CNT_W'(deq);
        q_wr_d     = q_wr_q + PTR_W'(resp_ok);
        q_rd_d     = q_rd_q + PTR_W'(deq);
        tag_wr_d   = tag_wr_q + PTR_W'(grant);
        tag_rd_d   = tag_rd_q + PTR_W'(resp_ok);
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle is stale
            drop_d   = inflight_q - CNT_W'(rvalid_v);
            occ_d    = '0;
            q_wr_d   = '0;
            q_rd_d   = '0;
            tag_wr_d = '0;
            tag_rd_d = '0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (rvalid_v && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    // IF/ID next value: flush, then stall, then dequeue, else bubble
    always_comb begin
        ifid_valid_d = if_id_valid;
        ifid_pc_d    = if_id_pc;
        ifid_pc4_d   = if_id_pc4;
        ifid_instr_d = if_id_instr;
        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (occ_q != '0) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = q_pc[q_rd_q];
                ifid_pc4_d   = q_pc[q_rd_q] + 32'd4;
                ifid_instr_d = q_instr[q_rd_q];
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_q  <= '0;
            drop_q      <= '0;
            occ_q       <= '0;
            q_rd_q      <= '0;
            q_wr_q      <= '0;
            tag_rd_q    <= '0;
            tag_wr_q    <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= RESET_PC;
            if_id_pc4   <= RESET_PC + 32'd4;
            if_id_instr <= NOP_INSTR;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            occ_q       <= occ_d;
            q_rd_q      <= q_rd_d;
            q_wr_q      <= q_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_wr_q    <= tag_wr_d;
            if_id_valid <= ifid_valid_d;
            if_id_pc    <= ifid_pc_d;
            if_id_pc4   <= ifid_pc4_d;
            if_id_instr <= ifid_instr_d;
        end
    end

    // Storage arrays need no reset; pointers and counts define validity
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (resp_ok) begin
            q_pc[q_wr_q]    <= tag_mem[tag_rd_q];
            q_instr[q_wr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model returning rdata = address,
// with hand-derived IF/ID and request expectations per cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 1;
    int mcyc     = 0;
    int max_out  = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: response `lat` cycles after grant, strictly in order; grants sampled just before the edge
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else if (pend.size() > 0 && pend[0].due <= mcyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #4;
        if (!rst && imem_req && imem_gnt) pend.push_back('{mcyc + lat, imem_addr});
        if (pend.size() + int'(imem_rvalid) > max_out) max_out = pend.size() + int'(imem_rvalid);
        mcyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4, 32'h4);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, "_pc"}, if_id_pc, pc);
        chk({tag, "_pc4"}, if_id_pc4, pc + 32'd4);
        chk({tag, "_instr"}, if_id_instr, pc);
    endtask

    // Leaves the bench at the negedge where rst falls: that cycle is cycle 0
    task automatic do_reset(input int latency);
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;
        lat            = latency;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;

        // Reset values and straight-line fetch with 1-cycle memory
        cyc(2);
        chk_reset_vals("rst");
        do_reset(1);
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        cyc(1);
        chk("c1_valid", 32'(if_id_valid), 32'd0);
        cyc(1);
        chk("c2_valid", 32'(if_id_valid), 32'd0);
        cyc(1);
        chk_ifid("c3", 32'h0);
        cyc(1);
        chk_ifid("c4", 32'h4);
        chk("c4_addr", imem_addr, 32'h10);
        cyc(1);
        chk_ifid("c5", 32'h8);

        // Stall three edges while IF/ID holds pc 8; credit closes at queue+inflight = 4
        stall = 1'b1;
        #1;
        chk("stall_c5_req", 32'(imem_req), 32'd1);
        cyc(1);
        chk_ifid("stall_c6", 32'h8);
        chk("stall_c6_req", 32'(imem_req), 32'd1);
        cyc(1);
        chk_ifid("stall_c7", 32'h8);
        chk("stall_c7_req", 32'(imem_req), 32'd0);
        cyc(1);
        chk_ifid("stall_c8", 32'h8);
        chk("stall_c8_req", 32'(imem_req), 32'd0);
        chk("stall_c8_addr", imem_addr, 32'h1C);
        stall = 1'b0;
        #1;
        chk("unstall_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk_ifid("post_stall", 32'h0C + 32'(4 * i));
        end

        // Redirect with two stale words in flight on 3-cycle memory
        do_reset(3);
        cyc(4);
        imem_gnt = 1'b0;
        cyc(1);
        chk_ifid("rd_c5", 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk("rd_req_low", 32'(imem_req), 32'd0);
        cyc(1);
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        chk("rd_c6_addr", imem_addr, 32'h100);
        for (int i = 6; i <= 10; i++) begin
            chk("rd_bubble_valid", 32'(if_id_valid), 32'd0);
            chk("rd_bubble_instr", if_id_instr, NOP);
            cyc(1);
        end
        chk_ifid("rd_c11", 32'h100);
        cyc(1);
        chk_ifid("rd_c12", 32'h104);

        // Flush beats stall; target low bits are dropped
        redirect_valid = 1'b1;
        stall          = 1'b1;
        redirect_pc    = 32'h0000_0203;
        cyc(1);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("flush_stall_valid", 32'(if_id_valid), 32'd0);
        chk("flush_stall_instr", if_id_instr, NOP);
        chk("flush_stall_addr", imem_addr, 32'h200);

        // Grant withheld for five cycles: PC holds, IF/ID drains then bubbles
        do_reset(1);
        cyc(4);
        chk("bp_c4_addr", imem_addr, 32'h10);
        imem_gnt = 1'b0;
        cyc(1);
        chk_ifid("bp_c5", 32'h8);
        cyc(1);
        chk_ifid("bp_c6", 32'hC);
        cyc(1);
        chk("bp_c7_valid", 32'(if_id_valid), 32'd0);
        chk("bp_c7_instr", if_id_instr, NOP);
        chk("bp_c7_pc", if_id_pc, 32'hC);
        cyc(1);
        chk("bp_c8_addr", imem_addr, 32'h10);
        cyc(1);
        chk("bp_c9_addr", imem_addr, 32'h10);
        chk("bp_c9_valid", 32'(if_id_valid), 32'd0);
        imem_gnt = 1'b1;
        cyc(2);
        chk("bp_c11_valid", 32'(if_id_valid), 32'd0);
        cyc(1);
        chk_ifid("bp_c12", 32'h10);

        // Asynchronous reset mid-stream at pc 0x40, then restart
        do_reset(1);
        cyc(19);
        chk_ifid("pre_arst", 32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk_ifid("restart_c3", 32'h0);
        cyc(1);
        chk_ifid("restart_c4", 32'h4);

        // PC wraps from 0xFFFF_FFFC to 0
        do_reset(1);
        cyc(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cyc(1);
        redirect_valid = 1'b0;
        chk("wrap_c4_valid", 32'(if_id_valid), 32'd0);
        chk("wrap_c4_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("wrap_c5_addr", imem_addr, 32'h0);
        cyc(2);
        chk_ifid("wrap_c7", 32'hFFFF_FFFC);
        cyc(1);
        chk_ifid("wrap_c8", 32'h0);

        chk("max_outstanding_ok", 32'(max_out <= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
